fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Instruction prefetch unit between a multi-cycle instruction memory and the IF/ID pipeline register of the MIPS pipeline. It owns the fetch PC and issues word fetches over a req/ack handshake, then buffers returned instructions with their PCs in a show-ahead FIFO. Stage 1 consumes the head whenever IF/ID loads. Branch/jump redirects from the PC-source logic flush the queue and restart fetch, and in-flight responses are discarded.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2
- RESET_PC, 32'h0, fetch PC after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  fetch request; held high until mem_ack
- mem_addr  out  32  word-aligned fetch address; stable while mem_req=1
- mem_ack  in  1  single-cycle pulse; completes the request, mem_rdata valid
- mem_rdata  in  32  returned instruction
- redirect  in  1  flush and restart fetch (PCSrc≠0)
- redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
- deq  in  1  consumer takes head (IF_IdWrite)
- inst_valid  out  1  queue non-empty
- inst_out  out  32  head instruction; 0 when empty
- inst_pc  out  32  head PC; 0 when empty
- inst_pc4  out  32  inst_pc+4 (mod 2^32); 0 when empty
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count==DEPTH

## Operation
- Storage: DEPTH entries of {instruction, pc}, with rd_ptr/wr_ptr wrapping modulo DEPTH. Head outputs are combinational from entry[rd_ptr].
- fetch_pc register: reset RESET_PC. +4 on each accepted (non-discarded) ack. Set to redirect_pc on redirect.
- FSM states: IDLE, WAIT, DROP. mem_req is registered and is 1 exactly in WAIT and DROP.
  - IDLE: if !redirect && count<DEPTH → WAIT, latch mem_addr=fetch_pc. Otherwise stay in IDLE.
  - WAIT: on mem_ack && !redirect → push {mem_rdata, mem_addr}, fetch_pc+=4, → IDLE. On mem_ack && redirect → discard, → IDLE. On !mem_ack && redirect → DROP. Otherwise hold.
  - DROP: hold req/addr; on mem_ack → discard, → IDLE. A further redirect in DROP only updates fetch_pc.
- Only one request is outstanding at a time. Issuing requires count<DEPTH, and since deq only lowers count, a push at ack never overflows.
- Redirect (any state): count←0, rd_ptr=wr_ptr←0, fetch_pc←redirect_pc. It overrides a same-cycle deq and push.
- deq with count==0: ignored, no pointer change.
- Push and deq in the same cycle: count unchanged, both pointers advance.
- Asynchronous reset mid-handshake: mem_req drops immediately and the outstanding request is abandoned. Memory must tolerate this.
- Reset values: mem_req=0, mem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc4=0, count=0, full=0, state=IDLE, fetch_pc=RESET_PC.

## Timing
- First edge after rst deassert: IDLE→WAIT. mem_req=1 and mem_addr=RESET_PC are visible in the following cycle.
- The ack edge writes the entry. inst_valid=1 from the next cycle, with 0-cycle head read (show-ahead).
- Minimum spacing between requests: ack edge→IDLE, next edge→WAIT. Peak throughput is 1 instruction per 2 cycles for a 1-cycle memory, or (L+1) cycles for ack latency L.
- deq takes effect at the edge where it is sampled high. The new head is visible in the next cycle.
- Redirect takes effect at the sampling edge. inst_valid=0 in the next cycle. The first post-redirect request is issued at the following IDLE edge, i.e. after any pending DROP ack.
- count, full and inst_valid are registered or derived from registers, with no combinational path from inputs.

## Test plan
- Reset, ack one cycle after each req, no deq → requests to 0,4,8,12. count reaches 4, full=1, mem_req stays 0 afterwards. Head is pc=0, inst_pc4=4.
- From full, deq held high for 4 cycles → heads at pc 0,4,8,12 in order. Requests to 16 onward resume once count<4. Pointers wrap correctly after the 8th push.
- count=2, push and deq in the same cycle → count stays 2. Next head is the previous second entry.
- Redirect to 0x40 while in WAIT (ack 3 cycles later, data 0xDEAD) → queue empties next cycle. 0xDEAD is never enqueued. The next request is to 0x40 and is issued only after the DROP ack.
- Redirect to 0x80 in the same cycle as mem_ack → data discarded, count=0, next request to 0x80.
- deq on empty → count stays 0, outputs 0. Assert rst during WAIT → mem_req=0 immediately. After release, first request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch unit: owns the fetch PC, issues one word fetch at a time
// over req/ack and buffers {instruction, pc} in a show-ahead FIFO for IF/ID.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [31:0]              inst_pc4,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            issue;
    logic            push;
    logic            pop;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     fetch_pc;
    logic [31:0]     redirect_aligned;
    logic [31:0]     q_inst [DEPTH];
    logic [31:0]     q_pc   [DEPTH];

    assign redirect_aligned = redirect_pc & ~32'h3;

    // A dequeue on an empty queue or during a flush has no effect.
    assign pop = deq && (count != '0) && !redirect;

    // Fetch FSM next state; a redirect with a request still in flight must
    // wait in DROP for the stale ack before a new request may go out.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!redirect && (count < CAP)) begin
                    state_nxt = WAIT;
                    issue     = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                    push      = !redirect;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with a registered request strobe and latched address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state   <= state_nxt;
            mem_req <= (state_nxt != IDLE);
            if (issue) begin
                mem_addr <= fetch_pc;
            end
        end
    end

    // Fetch PC follows redirects, otherwise advances on each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_aligned;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= mem_addr;
        end
    end

    assign inst_valid = (count != '0);
    assign full       = (count == CAP);
    assign inst_out   = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;
    assign inst_pc4   = inst_valid ? (q_pc[rd_ptr] + 32'd4) : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a memory model answers
// requests, a scoreboard holds expected {inst, pc} entries in fetch order.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [2:0]  count;
    logic        full;

    int          vectors;
    int          errors;
    int          lat;
    int          req_age;
    bit          dropping;
    bit          dead_mode;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;

    fetch_prefetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .deq(deq),
        .inst_valid(inst_valid),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .inst_pc4(inst_pc4),
        .count(count),
        .full(full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hA500_0000 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_pc    = RESET_PC;
        req_age   = 0;
        dropping  = 1'b0;
        dead_mode = 1'b0;
    endtask

    // One clock: drive inputs and memory response, score consumed heads and
    // new request addresses, advance the model, end at the next negedge.
    task automatic step(input logic d, input logic r, input logic [31:0] rpc);
        logic [63:0] e;
        deq         = d;
        redirect    = r;
        redirect_pc = rpc;
        mem_ack     = mem_req && (req_age == lat - 1);
        if (mem_ack) begin
            mem_rdata = dead_mode ? 32'h0000_DEAD : data_of(mem_addr);
        end else begin
            mem_rdata = '0;
        end
        if (mem_req && req_age == 0) begin
            vectors++;
            if (mem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_addr: got %h want %h", mem_addr, exp_pc);
            end
        end
        if (d && !r && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (inst_valid !== 1'b1 || inst_out !== e[63:32] ||
                inst_pc !== e[31:0] || inst_pc4 !== e[31:0] + 32'd4) begin
                errors++;
                $display("FAIL head: got v=%b %h@%h pc4=%h want %h@%h",
                         inst_valid, inst_out, inst_pc, inst_pc4,
                         e[63:32], e[31:0]);
            end
        end
        if (mem_ack && !r && !dropping) begin
            exp_q.push_back({mem_rdata, mem_addr});
            exp_pc = exp_pc + 32'd4;
        end
        if (r) begin
            exp_q.delete();
            exp_pc = rpc & ~32'h3;
        end
        if (mem_ack) begin
            dropping = 1'b0;
        end else if (r && mem_req) begin
            dropping = 1'b1;
        end
        if (mem_ack || !mem_req) begin
            req_age = 0;
        end else begin
            req_age++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        deq         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        lat         = 1;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({mem_req, inst_valid, full} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got req/valid/full=%b want 000",
                     {mem_req, inst_valid, full});
        end
        vectors++;
        if (mem_addr !== 32'h0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_addr_count: got %h/%0d want 0/0", mem_addr, count);
        end
        vectors++;
        if (inst_out !== 32'h0 || inst_pc !== 32'h0 || inst_pc4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_head: got %h %h %h want zeros",
                     inst_out, inst_pc, inst_pc4);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h",
                     mem_req, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_fill();
        int n;
        lat = 1;
        n = 0;
        while (exp_q.size() < DEPTH && n < 40) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        vectors++;
        if (n >= 40) begin
            errors++;
            $display("FAIL fill_timeout: got %0d entries want %0d", exp_q.size(), DEPTH);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            vectors++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL full_no_req: got req=%b want 0", mem_req);
            end
        end
        vectors++;
        if (count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_count: got %0d/%b want 4/1", count, full);
        end
        vectors++;
        if (inst_pc !== 32'h0 || inst_pc4 !== 32'h4 || inst_out !== data_of(32'h0)) begin
            errors++;
            $display("FAIL full_head: got %h@%h pc4=%h want %h@0 pc4=4",
                     inst_out, inst_pc, inst_pc4, data_of(32'h0));
        end
    endtask

    task automatic test_drain_wrap();
        int n;
        repeat (4) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(i[0], 1'b0, 32'h0);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step(1'b1, 1'b0, 32'h0);
            n++;
        end
        vectors++;
        if (count !== 3'd0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got count=%0d valid=%b want 0/0",
                     count, inst_valid);
        end
    endtask

    task automatic test_push_deq();
        int          n;
        logic [31:0] second_pc;
        logic [31:0] second_inst;
        lat = 3;
        step(1'b0, 1'b1, 32'h100);
        n = 0;
        while (exp_q.size() < 2 && n < 60) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        n = 0;
        while (!(mem_req && req_age == lat - 1) && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        vectors++;
        if (n >= 20 || count !== 3'd2) begin
            errors++;
            $display("FAIL pd_setup: got count=%0d wait=%0d want 2", count, n);
        end
        second_pc   = exp_q[1][31:0];
        second_inst = exp_q[1][63:32];
        step(1'b1, 1'b0, 32'h0);
        vectors++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL pd_count: got %0d want 2", count);
        end
        vectors++;
        if (inst_pc !== second_pc || inst_out !== second_inst) begin
            errors++;
            $display("FAIL pd_head: got %h@%h want %h@%h",
                     inst_out, inst_pc, second_inst, second_pc);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        lat = 4;
        n = 0;
        while (!(mem_req && req_age == 0) && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        dead_mode = 1'b1;
        step(1'b0, 1'b1, 32'h40);
        vectors++;
        if (inst_valid !== 1'b0 || count !== 3'd0 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rw_flush: got valid=%b count=%0d req=%b want 0/0/1",
                     inst_valid, count, mem_req);
        end
        n = 0;
        while (mem_req && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        dead_mode = 1'b0;
        vectors++;
        if (n !== 3 || count !== 3'd0) begin
            errors++;
            $display("FAIL rw_drop: got %0d cycles count=%0d want 3/0", n, count);
        end
        step(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL rw_next_req: got req=%b addr=%h want 1/00000040",
                     mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_ack();
        int n;
        lat = 2;
        n = 0;
        while (!(mem_req && req_age == lat - 1) && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        step(1'b0, 1'b1, 32'h83);
        vectors++;
        if (count !== 3'd0 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ra_flush: got count=%0d valid=%b req=%b want 0/0/0",
                     count, inst_valid, mem_req);
        end
        step(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL ra_next_req: got req=%b addr=%h want 1/00000080",
                     mem_req, mem_addr);
        end
    endtask

    task automatic test_deq_empty();
        lat = 30;
        step(1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            vectors++;
            if (count !== 3'd0 || inst_valid !== 1'b0 || inst_out !== 32'h0 ||
                inst_pc !== 32'h0 || inst_pc4 !== 32'h0) begin
                errors++;
                $display("FAIL deq_empty: got count=%0d v=%b %h %h %h want zeros",
                         count, inst_valid, inst_out, inst_pc, inst_pc4);
            end
        end
    endtask

    task automatic test_reset_midwait();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL async_rst: got req=%b count=%0d want 0/0", mem_req, count);
        end
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b0;
        lat     = 1;
        model_reset();
        step(1'b0, 1'b0, 32'h0);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rst_first_req: got req=%b addr=%h want 1/%h",
                     mem_req, mem_addr, RESET_PC);
        end
        for (int i = 0; i < 12; i++) begin
            step(i[0], 1'b0, 32'h0);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_push_deq();
        test_redirect_wait();
        test_redirect_ack();
        test_deq_empty();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
